scan_test_sequencer: RTL and testbench
======================================

Name: scan_test_sequencer

Overview:
- Drives the full-scan version of an ISCAS-style sequential circuit under test (CUT), e.g. s298 with its 14 flops stitched into one chain.
- Accepts test patterns over a valid/ready interface and loads each one serially into the chain. It then applies the primary inputs for a single capture cycle and unloads the response while the next pattern loads.
- Compares the unloaded bits and the captured primary outputs against expected values, and reports pass/fail per pattern plus a running fail count.
- Sits between the pattern source (bench or BIST ROM) and the CUT's scan ports.

Parameters:
- CHAIN_LEN, 14, number of scan cells in the chain.
- PI_W, 3, CUT primary input width.
- PO_W, 6, CUT primary output width.
- CNT_W, 16, width of pattern index and fail counter.

Ports:
- CK  in  1  single clock; the sequencer and CUT scan flops share it.
- RST  in  1  reset, synchronous, active-high.
- pat_valid  in  1  pattern offered.
- pat_ready  out  1  sequencer accepts a pattern this cycle.
- pat_scan  in  CHAIN_LEN  scan load value; bit j ends in cell j (cell 0 nearest scan_out).
- pat_pi  in  PI_W  primary inputs applied at capture.
- pat_last  in  1  marks the final pattern of the set.
- exp_scan  in  CHAIN_LEN  expected captured chain state for this pattern.
- exp_po  in  PO_W  expected primary outputs at capture.
- scan_en  out  1  CUT scan enable (1 = shift).
- scan_in  out  1  serial data into the chain.
- scan_out  in  1  serial data from chain cell 0.
- cut_pi  out  PI_W  CUT primary inputs.
- cut_po  in  PO_W  CUT primary outputs.
- cut_ck_en  out  1  CUT clock enable.
- res_valid  out  1  one-cycle result strobe.
- res_fail  out  1  result for pattern res_index (1 = mismatch).
- res_index  out  CNT_W  pattern number of the result, starting at 0.
- fail_count  out  CNT_W  saturating count of failing patterns.
- done  out  1  pattern set complete.

Behaviour:
- Reset (RST high at CK edge) forces all outputs to 0, state IDLE, and clears all counters and flags.
  - pat_ready rises the cycle after RST deasserts.
  - Reset mid-operation abandons the pattern; chain contents are don't-care.
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE:
  - pat_ready=1, scan_en=0, cut_ck_en=0.
  - On pat_valid, latch pat_scan/pat_pi/pat_last/exp_scan/exp_po, clear shift counter k, go to SHIFT.
- SHIFT, CHAIN_LEN cycles, k=0..CHAIN_LEN-1:
  - scan_en=1, cut_ck_en=1, scan_in=pat_scan[k].
  - If a previous capture is pending (have_prev), compare scan_out against prev_exp_scan[k] and OR any mismatch into the scan-fail flag.
  - After cycle k=CHAIN_LEN-1, go to CAPTURE.
- CAPTURE, 1 cycle:
  - scan_en=0, cut_ck_en=1, cut_pi=latched pat_pi.
  - po_fail = (cut_po != exp_po), sampled this cycle.
  - Move the current expectations into the prev_* registers and set have_prev=1.
  - Next state is UNLOAD if pat_last, else IDLE.
- UNLOAD, CHAIN_LEN cycles: same as SHIFT but with scan_in=0; then go to DONE.
- DONE: done=1 and pat_ready=0, sticky until RST.
- cut_pi holds its last value outside CAPTURE.
- Result emission:
  - Fires on the cycle after the last SHIFT or UNLOAD cycle in which have_prev was 1.
  - res_valid=1 for one cycle; res_fail = prev_po_fail | scan-fail flag.
  - res_index increments after each strobe.
  - fail_count += res_fail, saturating at all-ones.
  - The scan-fail flag clears when the strobe fires.
- The first pattern's SHIFT performs no compare, so no result is emitted.
- Per-pattern minimum period is CHAIN_LEN+2 cycles (IDLE, SHIFT, CAPTURE).
- pat_valid is ignored outside IDLE.
- pat_last with CHAIN_LEN=1 is legal: 1 shift cycle, 1 unload cycle.

Decomposition:
- Package scan_seq_pkg holds:
  - state enum {IDLE, SHIFT, CAPTURE, UNLOAD, DONE};
  - default constants CHAIN_LEN_DEF=14, PI_W_DEF=3, PO_W_DEF=6, CNT_W_DEF=16;
  - saturating-increment function.
- One sub-module, scan_shift_compare, contains the shift counter, scan_in mux, scan_out compare and mismatch accumulator. The top-level FSM instantiates it.

Test Plan:
1. Reset: hold RST 3 cycles -> every output 0. Release -> pat_ready=1 next cycle; scan_en=0, done=0.
2. Single pattern, pat_scan=14'h2A5C, pat_pi=3'b101, pat_last=1, CUT model chain with capture D=~Q, exp_scan=14'h15A3:
   - scan_in drives bits 0..13 of 14'h2A5C over 14 cycles;
   - cut_pi=3'b101 in CAPTURE only;
   - 14 unload cycles, then res_valid with res_fail=0, res_index=0, fail_count=0, done=1.
3. Scan mismatch: same as 2 but exp_scan bit 3 flipped -> res_fail=1, fail_count=1.
4. PO mismatch: exp_po=6'h00 with model cut_po=6'h21 -> res_fail=1 even though the scan compare passes.
5. Overlap: patterns A (pat_last=0) then B (pat_last=1) offered back-to-back:
   - result for A (index 0) fires the cycle after B's 14th shift cycle;
   - result for B (index 1) fires after UNLOAD;
   - exactly two res_valid pulses.
6. Reset mid-SHIFT at k=7 -> scan_en=0 and cut_ck_en=0 next cycle, no res_valid, fail_count=0. A fresh pattern then runs as in scenario 2.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Purpose : shared types, default sizes and helpers for the scan test sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: state_e FSM encoding, *_DEF default parameters, sat_inc() saturating increment.
package scan_seq_pkg;

   localparam int CHAIN_LEN_DEF = 14;
   localparam int PI_W_DEF      = 3;
   localparam int PO_W_DEF      = 6;
   localparam int CNT_W_DEF     = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      CAPTURE = 3'd2,
      UNLOAD  = 3'd3,
      DONE    = 3'd4
   } state_e;

   // Increment v, sticking at the all-ones value of a w-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? max_v : (v + 32'd1);
   endfunction

endpackage

// File: rtl/scan_shift_compare.sv
// Purpose : scan shift counter, scan_in bit select, scan_out compare and sticky mismatch flag.
// Latency : scan_in/fail_now combinational from the current shift index; k advances every shift cycle.
// Backpressure: none; shifts whenever shift_en is high, counter parks at 0 otherwise.
// Ports   : clk/rst, shift_en, use_pat (drive pattern bits vs 0), cmp_en, clr_acc,
//           pat_scan/exp_scan vectors, scan_out in; scan_in, k_last, fail_now out.
module scan_shift_compare
   import scan_seq_pkg::*;
#(
   parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 shift_en,
   input  logic                 use_pat,
   input  logic                 cmp_en,
   input  logic                 clr_acc,
   input  logic [CHAIN_LEN-1:0] pat_scan,
   input  logic [CHAIN_LEN-1:0] exp_scan,
   input  logic                 scan_out,
   output logic                 scan_in,
   output logic                 k_last,
   output logic                 fail_now
);

   localparam int KW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

   logic [KW-1:0] k_q, k_d;
   logic          acc_q, acc_d;
   logic          bit_miss;

   always_comb begin
      k_last   = (k_q == KW'(CHAIN_LEN - 1));
      // Counter returns to 0 on the last shift so the next phase starts clean.
      k_d      = (shift_en && !k_last) ? (k_q + KW'(1)) : '0;
      scan_in  = use_pat ? pat_scan[k_q] : 1'b0;
      // Cell k of the previous capture appears on scan_out during shift cycle k.
      bit_miss = shift_en && cmp_en && (scan_out != exp_scan[k_q]);
      // fail_now includes this cycle's bit so the final shift cycle is counted.
      fail_now = acc_q | bit_miss;
      acc_d    = clr_acc ? 1'b0 : fail_now;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q   <= '0;
         acc_q <= 1'b0;
      end else begin
         k_q   <= k_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/scan_test_sequencer.sv
// Purpose : loads patterns into a full-scan CUT, captures once, unloads while the next loads, checks responses.
// Latency : CHAIN_LEN+2 cycles per pattern; result strobe the cycle after the compare-shift phase ends.
// Backpressure: pat_ready only in IDLE (after reset settles); pat_valid ignored in every other state.
// Ports   : CK/RST; pattern in (pat_valid/pat_ready, pat_scan, pat_pi, pat_last, exp_scan, exp_po);
//           CUT side (scan_en, scan_in, scan_out, cut_pi, cut_po, cut_ck_en);
//           results (res_valid, res_fail, res_index, fail_count, done).
module scan_test_sequencer
   import scan_seq_pkg::*;
#(
   parameter int CHAIN_LEN = CHAIN_LEN_DEF,
   parameter int PI_W      = PI_W_DEF,
   parameter int PO_W      = PO_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                 CK,
   input  logic                 RST,
   input  logic                 pat_valid,
   output logic                 pat_ready,
   input  logic [CHAIN_LEN-1:0] pat_scan,
   input  logic [PI_W-1:0]      pat_pi,
   input  logic                 pat_last,
   input  logic [CHAIN_LEN-1:0] exp_scan,
   input  logic [PO_W-1:0]      exp_po,
   output logic                 scan_en,
   output logic                 scan_in,
   input  logic                 scan_out,
   output logic [PI_W-1:0]      cut_pi,
   input  logic [PO_W-1:0]      cut_po,
   output logic                 cut_ck_en,
   output logic                 res_valid,
   output logic                 res_fail,
   output logic [CNT_W-1:0]     res_index,
   output logic [CNT_W-1:0]     fail_count,
   output logic                 done
);

   state_e                 state_q, state_d;
   logic                   armed_q, armed_d;
   logic [CHAIN_LEN-1:0]   pat_scan_q, pat_scan_d;
   logic [PI_W-1:0]        pat_pi_q, pat_pi_d;
   logic                   pat_last_q, pat_last_d;
   logic [CHAIN_LEN-1:0]   exp_scan_q, exp_scan_d;
   logic [PO_W-1:0]        exp_po_q, exp_po_d;
   logic [CHAIN_LEN-1:0]   prev_exp_scan_q, prev_exp_scan_d;
   logic                   prev_po_fail_q, prev_po_fail_d;
   logic                   have_prev_q, have_prev_d;
   logic [PI_W-1:0]        cut_pi_q, cut_pi_d;
   logic                   res_valid_q, res_valid_d;
   logic                   res_fail_q, res_fail_d;
   logic [CNT_W-1:0]       res_index_q, res_index_d;
   logic [CNT_W-1:0]       fail_count_q, fail_count_d;

   logic shift_en;
   logic use_pat;
   logic strobe;
   logic k_last;
   logic fail_now;
   logic pat_fail;

   assign shift_en = (state_q == SHIFT) || (state_q == UNLOAD);
   assign use_pat  = (state_q == SHIFT);
   // Last cycle of a shift phase that was also unloading a real capture.
   assign strobe   = shift_en && k_last && have_prev_q;
   assign pat_fail = prev_po_fail_q | fail_now;

   scan_shift_compare #(
      .CHAIN_LEN (CHAIN_LEN)
   ) u_shift (
      .clk       (CK),
      .rst       (RST),
      .shift_en  (shift_en),
      .use_pat   (use_pat),
      .cmp_en    (have_prev_q),
      .clr_acc   (strobe),
      .pat_scan  (pat_scan_q),
      .exp_scan  (prev_exp_scan_q),
      .scan_out  (scan_out),
      .scan_in   (scan_in),
      .k_last    (k_last),
      .fail_now  (fail_now)
   );

   always_comb begin
      state_d         = state_q;
      // armed_q holds pat_ready low for the first cycle after reset.
      armed_d         = 1'b1;
      pat_scan_d      = pat_scan_q;
      pat_pi_d        = pat_pi_q;
      pat_last_d      = pat_last_q;
      exp_scan_d      = exp_scan_q;
      exp_po_d        = exp_po_q;
      prev_exp_scan_d = prev_exp_scan_q;
      prev_po_fail_d  = prev_po_fail_q;
      have_prev_d     = have_prev_q;
      cut_pi_d        = cut_pi_q;
      res_valid_d     = strobe;
      res_fail_d      = strobe && pat_fail;
      res_index_d     = res_valid_q ? (res_index_q + CNT_W'(1)) : res_index_q;
      fail_count_d    = (strobe && pat_fail) ? CNT_W'(sat_inc(32'(fail_count_q), CNT_W)) : fail_count_q;

      case (state_q)
         IDLE: begin
            if (pat_valid && armed_q) begin
               pat_scan_d = pat_scan;
               pat_pi_d   = pat_pi;
               pat_last_d = pat_last;
               exp_scan_d = exp_scan;
               exp_po_d   = exp_po;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (k_last) begin
               // Register the PIs now so they are stable for the whole capture cycle.
               cut_pi_d = pat_pi_q;
               state_d  = CAPTURE;
            end
         end
         CAPTURE: begin
            prev_exp_scan_d = exp_scan_q;
            prev_po_fail_d  = (cut_po != exp_po_q);
            have_prev_d     = 1'b1;
            state_d         = pat_last_q ? UNLOAD : IDLE;
         end
         UNLOAD: begin
            if (k_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         state_q         <= IDLE;
         armed_q         <= 1'b0;
         pat_scan_q      <= '0;
         pat_pi_q        <= '0;
         pat_last_q      <= 1'b0;
         exp_scan_q      <= '0;
         exp_po_q        <= '0;
         prev_exp_scan_q <= '0;
         prev_po_fail_q  <= 1'b0;
         have_prev_q     <= 1'b0;
         cut_pi_q        <= '0;
         res_valid_q     <= 1'b0;
         res_fail_q      <= 1'b0;
         res_index_q     <= '0;
         fail_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         armed_q         <= armed_d;
         pat_scan_q      <= pat_scan_d;
         pat_pi_q        <= pat_pi_d;
         pat_last_q      <= pat_last_d;
         exp_scan_q      <= exp_scan_d;
         exp_po_q        <= exp_po_d;
         prev_exp_scan_q <= prev_exp_scan_d;
         prev_po_fail_q  <= prev_po_fail_d;
         have_prev_q     <= have_prev_d;
         cut_pi_q        <= cut_pi_d;
         res_valid_q     <= res_valid_d;
         res_fail_q      <= res_fail_d;
         res_index_q     <= res_index_d;
         fail_count_q    <= fail_count_d;
      end
   end

   assign pat_ready  = (state_q == IDLE) && armed_q;
   assign scan_en    = shift_en;
   assign cut_ck_en  = shift_en || (state_q == CAPTURE);
   assign cut_pi     = cut_pi_q;
   assign res_valid  = res_valid_q;
   assign res_fail   = res_fail_q;
   assign res_index  = res_index_q;
   assign fail_count = fail_count_q;
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_scan_test_sequencer.sv
// Purpose : bench for scan_test_sequencer with a behavioural scan CUT (capture D = ~Q, PO fixed at 6'h21).
// Latency : checks shift/capture/unload cycle by cycle; results scored from a queue at each strobe.
// Backpressure: waits on pat_ready with a bounded cycle budget.
module tb_scan_test_sequencer;

   localparam int CL = 14;

   logic          CK = 1'b0;
   logic          RST = 1'b1;
   logic          pat_valid = 1'b0;
   logic          pat_ready;
   logic [CL-1:0] pat_scan = '0;
   logic [2:0]    pat_pi = '0;
   logic          pat_last = 1'b0;
   logic [CL-1:0] exp_scan = '0;
   logic [5:0]    exp_po = '0;
   logic          scan_en;
   logic          scan_in;
   logic          scan_out;
   logic [2:0]    cut_pi;
   logic [5:0]    cut_po;
   logic          cut_ck_en;
   logic          res_valid;
   logic          res_fail;
   logic [15:0]   res_index;
   logic [15:0]   fail_count;
   logic          done;

   scan_test_sequencer dut (
      .CK(CK), .RST(RST), .pat_valid(pat_valid), .pat_ready(pat_ready),
      .pat_scan(pat_scan), .pat_pi(pat_pi), .pat_last(pat_last),
      .exp_scan(exp_scan), .exp_po(exp_po), .scan_en(scan_en), .scan_in(scan_in),
      .scan_out(scan_out), .cut_pi(cut_pi), .cut_po(cut_po), .cut_ck_en(cut_ck_en),
      .res_valid(res_valid), .res_fail(res_fail), .res_index(res_index),
      .fail_count(fail_count), .done(done)
   );

   always #5 CK = ~CK;

   // Behavioural CUT: scan_in enters the far cell, cell 0 drives scan_out.
   logic [CL-1:0] cells = '0;
   always @(posedge CK) begin
      if (cut_ck_en) begin
         if (scan_en) cells <= {scan_in, cells[CL-1:1]};
         else         cells <= ~cells;
      end
   end
   assign scan_out = cells[0];
   assign cut_po   = 6'h21;

   typedef struct {
      logic        fail;
      logic [15:0] idx;
      logic [15:0] fcnt;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          pulses = 0;
   logic        pending = 1'b0;
   logic [15:0] exp_idx = '0;
   logic [15:0] exp_fcnt = '0;

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   // Result scoreboard.
   always @(posedge CK) begin
      exp_t e;
      #1;
      if (res_valid === 1'b1) begin
         pulses++;
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL res_unexpected: strobe idx=%0d with nothing outstanding", res_index);
         end else begin
            e = sb.pop_front();
            if ({res_fail, res_index, fail_count} !== {e.fail, e.idx, e.fcnt}) begin
               n_err++;
               $display("FAIL res_check: got fail=%b idx=%0d cnt=%0d, want fail=%b idx=%0d cnt=%0d",
                        res_fail, res_index, fail_count, e.fail, e.idx, e.fcnt);
            end
         end
      end
   end

   task automatic do_reset(input int n);
      RST = 1'b1;
      pat_valid = 1'b0;
      repeat (n) step();
      RST = 1'b0;
      sb.delete();
      pending  = 1'b0;
      exp_idx  = '0;
      exp_fcnt = '0;
   endtask

   task automatic apply_pattern(input logic [CL-1:0] ps, input logic [2:0] pi, input logic last,
                                input logic [CL-1:0] es, input logic [5:0] ep);
      int   w;
      logic f;
      w = 0;
      while (pat_ready !== 1'b1 && w < 40) begin
         step();
         w++;
      end
      n_vec++;
      if (pat_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ready_wait: pat_ready=%b after %0d cycles, want 1", pat_ready, w);
         return;
      end
      pat_valid = 1'b1; pat_scan = ps; pat_pi = pi; pat_last = last; exp_scan = es; exp_po = ep;
      f = (es != ~ps) || (ep != 6'h21);
      if (f && exp_fcnt != 16'hFFFF) exp_fcnt = exp_fcnt + 16'd1;
      sb.push_back('{f, exp_idx, exp_fcnt});
      exp_idx = exp_idx + 16'd1;
      step();
      pat_valid = 1'b0;
      for (int k = 0; k < CL; k++) begin
         n_vec++;
         if ({scan_en, cut_ck_en, scan_in, res_valid, pat_ready} !== {1'b1, 1'b1, ps[k], 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL shift_k%0d: en/ck/si/rv/rdy=%b%b%b%b%b want 11%b00",
                     k, scan_en, cut_ck_en, scan_in, res_valid, pat_ready, ps[k]);
         end
         step();
      end
      n_vec++;
      if ({scan_en, cut_ck_en, cut_pi, res_valid} !== {1'b0, 1'b1, pi, pending}) begin
         n_err++;
         $display("FAIL capture: en=%b ck=%b pi=%b rv=%b want en=0 ck=1 pi=%b rv=%b",
                  scan_en, cut_ck_en, cut_pi, res_valid, pi, pending);
      end
      pending = 1'b1;
      step();
      if (last) begin
         for (int k = 0; k < CL; k++) begin
            n_vec++;
            if ({scan_en, cut_ck_en, scan_in, res_valid, done} !== 5'b11000) begin
               n_err++;
               $display("FAIL unload_k%0d: en/ck/si/rv/done=%b%b%b%b%b want 11000",
                        k, scan_en, cut_ck_en, scan_in, res_valid, done);
            end
            step();
         end
         n_vec++;
         if ({done, pat_ready, res_valid, scan_en, cut_ck_en} !== 5'b10100) begin
            n_err++;
            $display("FAIL done_state: done/rdy/rv/en/ck=%b%b%b%b%b want 10100",
                     done, pat_ready, res_valid, scan_en, cut_ck_en);
         end
      end else begin
         n_vec++;
         if ({pat_ready, done, scan_en} !== 3'b100) begin
            n_err++;
            $display("FAIL back_to_idle: rdy/done/en=%b%b%b want 100", pat_ready, done, scan_en);
         end
      end
   endtask

   task automatic check_drained(input string name);
      step();
      step();
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL %s_drained: %0d results outstanding, want 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_vec++;
         if ({pat_ready, scan_en, scan_in, cut_pi, cut_ck_en, res_valid, res_fail,
              res_index, fail_count, done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_c%0d: rdy=%b en=%b si=%b pi=%b ck=%b rv=%b rf=%b idx=%0d cnt=%0d done=%b, want all 0",
                     i, pat_ready, scan_en, scan_in, cut_pi, cut_ck_en, res_valid, res_fail,
                     res_index, fail_count, done);
         end
      end
      RST = 1'b0;
      n_vec++;
      if (pat_ready !== 1'b0) begin
         n_err++;
         $display("FAIL ready_early: pat_ready=%b before first edge out of reset, want 0", pat_ready);
      end
      step();
      n_vec++;
      if ({pat_ready, scan_en, done} !== 3'b100) begin
         n_err++;
         $display("FAIL ready_after_reset: rdy/en/done=%b%b%b want 100", pat_ready, scan_en, done);
      end
   endtask

   task automatic test_single();
      do_reset(2);
      n_vec++;
      if (cut_pi !== 3'b000) begin
         n_err++;
         $display("FAIL cut_pi_before_capture: got %b want 000", cut_pi);
      end
      apply_pattern(14'h2A5C, 3'b101, 1'b1, 14'h15A3, 6'h21);
      check_drained("single");
   endtask

   task automatic test_scan_mismatch();
      do_reset(2);
      apply_pattern(14'h2A5C, 3'b101, 1'b1, 14'h15A3 ^ 14'h0008, 6'h21);
      check_drained("scan_mismatch");
   endtask

   task automatic test_po_mismatch();
      do_reset(2);
      apply_pattern(14'h2A5C, 3'b101, 1'b1, 14'h15A3, 6'h00);
      check_drained("po_mismatch");
   endtask

   task automatic test_back_to_back();
      int p0;
      do_reset(2);
      p0 = pulses;
      apply_pattern(14'h1234, 3'b010, 1'b0, ~14'h1234, 6'h21);
      apply_pattern(14'h3C0F, 3'b011, 1'b1, ~14'h3C0F ^ 14'h2000, 6'h21);
      repeat (3) step();
      n_vec++;
      if (pulses - p0 != 2) begin
         n_err++;
         $display("FAIL overlap_pulses: got %0d strobes want 2", pulses - p0);
      end
      check_drained("overlap");
   endtask

   task automatic test_reset_mid_shift();
      do_reset(2);
      apply_pattern(14'h0F0F, 3'b110, 1'b0, 14'h0000, 6'h21);
      pat_valid = 1'b1; pat_scan = 14'h3333; pat_pi = 3'b001; pat_last = 1'b1;
      exp_scan = ~14'h3333; exp_po = 6'h21;
      step();
      pat_valid = 1'b0;
      repeat (7) step();
      n_vec++;
      if (scan_en !== 1'b1) begin
         n_err++;
         $display("FAIL mid_shift_active: scan_en=%b at k=7, want 1", scan_en);
      end
      RST = 1'b1;
      step();
      n_vec++;
      if ({scan_en, cut_ck_en, res_valid, fail_count} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
         n_err++;
         $display("FAIL mid_shift_reset: en=%b ck=%b rv=%b cnt=%0d want 0 0 0 0",
                  scan_en, cut_ck_en, res_valid, fail_count);
      end
      do_reset(1);
      apply_pattern(14'h2A5C, 3'b101, 1'b1, 14'h15A3, 6'h21);
      check_drained("after_mid_reset");
   endtask

   initial begin
      test_reset();
      test_single();
      test_scan_mismatch();
      test_po_mismatch();
      test_back_to_back();
      test_reset_mid_shift();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
